vending_txn_controller: RTL and testbench

Transaction sequencer for the vending machine. It accumulates inserted coins into a running total and owns the inactivity timer. It dispenses affordable selected items and returns change greedily, one coin per cycle, on a return request or timeout. It sits between the coin/button front end and the item/coin output actuators.

---
 rtl/vending_txn_controller.sv | 168 ++++++++++++++++
 tb/tb_vending_txn_controller.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/vending_txn_controller.sv
// Vending transaction sequencer: credits coins, dispenses affordable items, and pays change greedily one coin per cycle.
// All outputs except o_available_item are registered.
module vending_txn_controller #(
   parameter int unsigned COIN_VAL0   = 100,
   parameter int unsigned COIN_VAL1   = 500,
   parameter int unsigned COIN_VAL2   = 1000,
   parameter int unsigned ITEM_PRICE0 = 400,
   parameter int unsigned ITEM_PRICE1 = 500,
   parameter int unsigned ITEM_PRICE2 = 1000,
   parameter int unsigned ITEM_PRICE3 = 2000,
   parameter int unsigned WAIT_TIME   = 100,
   parameter int unsigned MAX_TOTAL   = 65535
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [2:0]  i_input_coin,
   input  logic [3:0]  i_select_item,
   input  logic        i_trigger_return,
   output logic [15:0] o_current_total,
   output logic [3:0]  o_available_item,
   output logic [3:0]  o_output_item,
   output logic [2:0]  o_return_coin,
   output logic [7:0]  o_wait_time,
   output logic        o_busy
);

   typedef enum logic [1:0] {IDLE, ACTIVE, RETURN} state_t;

   localparam logic [16:0] CV0  = 17'(COIN_VAL0);
   localparam logic [16:0] CV1  = 17'(COIN_VAL1);
   localparam logic [16:0] CV2  = 17'(COIN_VAL2);
   localparam logic [16:0] P0   = 17'(ITEM_PRICE0);
   localparam logic [16:0] P1   = 17'(ITEM_PRICE1);
   localparam logic [16:0] P2   = 17'(ITEM_PRICE2);
   localparam logic [16:0] P3   = 17'(ITEM_PRICE3);
   localparam logic [16:0] MAXT = 17'(MAX_TOTAL);
   localparam logic [7:0]  WT   = 8'(WAIT_TIME);

   state_t      state;
   logic [15:0] total;
   logic [7:0]  timer;
   logic [3:0]  item_q;
   logic [2:0]  coin_q;

   logic [16:0] total17;
   logic [16:0] coin_sum;
   logic [16:0] sum17;
   logic        coin_ok;
   logic        coin_any;
   logic        sel_hit;
   logic [1:0]  sel_idx;
   logic [16:0] sel_price;
   logic [15:0] sel_left;
   logic [2:0]  chg_coin;
   logic [15:0] chg_left;

   assign total17  = {1'b0, total};
   assign coin_any = |i_input_coin;
   assign coin_sum = (i_input_coin[0] ? CV0 : 17'd0)
                   + (i_input_coin[1] ? CV1 : 17'd0)
                   + (i_input_coin[2] ? CV2 : 17'd0);
   assign sum17    = total17 + coin_sum;
   assign coin_ok  = (sum17 <= MAXT);

   // Only the lowest-index pressed button counts.
   always_comb begin
      sel_hit = 1'b0;
      sel_idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (i_select_item[i]) begin
            sel_hit = 1'b1;
            sel_idx = 2'(i);
         end
      end
   end

   always_comb begin
      sel_price = P0;
      case (sel_idx)
         2'd0: sel_price = P0;
         2'd1: sel_price = P1;
         2'd2: sel_price = P2;
         2'd3: sel_price = P3;
         default: sel_price = P0;
      endcase
   end

   // Subtraction is only used after the 17-bit compare proves total >= price.
   assign sel_left = total - sel_price[15:0];

   always_comb begin
      chg_coin = 3'b000;
      chg_left = total;
      if (total17 >= CV2) begin
         chg_coin = 3'b100;
         chg_left = total - CV2[15:0];
      end else if (total17 >= CV1) begin
         chg_coin = 3'b010;
         chg_left = total - CV1[15:0];
      end else if (total17 >= CV0) begin
         chg_coin = 3'b001;
         chg_left = total - CV0[15:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state  <= IDLE;
         total  <= 16'd0;
         timer  <= 8'd0;
         item_q <= 4'd0;
         coin_q <= 3'd0;
      end else begin
         item_q <= 4'd0;
         coin_q <= 3'd0;
         case (state)
            IDLE: begin
               if (coin_any) begin
                  if (coin_ok) begin
                     total <= sum17[15:0];
                     timer <= WT;
                     state <= ACTIVE;
                  end else begin
                     coin_q <= i_input_coin;
                  end
               end
            end
            ACTIVE: begin
               if (i_trigger_return || timer == 8'd0) begin
                  state <= RETURN;
               end else if (coin_any) begin
                  if (coin_ok) begin
                     total <= sum17[15:0];
                     timer <= WT;
                  end else begin
                     coin_q <= i_input_coin;
                  end
               end else if (sel_hit && total17 >= sel_price) begin
                  item_q <= 4'(1) << sel_idx;
                  total  <= sel_left;
                  timer  <= WT;
               end else begin
                  timer <= timer - 8'd1;
               end
            end
            RETURN: begin
               if (chg_coin != 3'b000) begin
                  coin_q <= chg_coin;
                  total  <= chg_left;
               end else begin
                  // Either nothing left or a residue below the smallest coin, which is forfeited.
                  total <= 16'd0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign o_current_total  = total;
   assign o_available_item = {total17 >= P3, total17 >= P2, total17 >= P1, total17 >= P0};
   assign o_output_item    = item_q;
   assign o_return_coin    = coin_q;
   assign o_wait_time      = timer;
   assign o_busy           = (state == RETURN);

endmodule

// File: tb/tb_vending_txn_controller.sv
// Scoreboard bench for vending_txn_controller: default instance plus a MAX_TOTAL=1000 instance for overflow.
module tb_vending_txn_controller;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;

   logic [2:0]  coin_a = '0;
   logic [3:0]  sel_a = '0;
   logic        ret_a = 1'b0;
   logic [15:0] total_a;
   logic [3:0]  avail_a;
   logic [3:0]  item_a;
   logic [2:0]  rcoin_a;
   logic [7:0]  wait_a;
   logic        busy_a;

   logic [2:0]  coin_b = '0;
   logic [3:0]  sel_b = '0;
   logic        ret_b = 1'b0;
   logic [15:0] total_b;
   logic [3:0]  avail_b;
   logic [3:0]  item_b;
   logic [2:0]  rcoin_b;
   logic [7:0]  wait_b;
   logic        busy_b;

   always #5 clk = ~clk;

   vending_txn_controller u_dut (
      .clk(clk), .reset_n(reset_n),
      .i_input_coin(coin_a), .i_select_item(sel_a), .i_trigger_return(ret_a),
      .o_current_total(total_a), .o_available_item(avail_a), .o_output_item(item_a),
      .o_return_coin(rcoin_a), .o_wait_time(wait_a), .o_busy(busy_a)
   );

   vending_txn_controller #(.MAX_TOTAL(1000)) u_dut_small (
      .clk(clk), .reset_n(reset_n),
      .i_input_coin(coin_b), .i_select_item(sel_b), .i_trigger_return(ret_b),
      .o_current_total(total_b), .o_available_item(avail_b), .o_output_item(item_b),
      .o_return_coin(rcoin_b), .o_wait_time(wait_b), .o_busy(busy_b)
   );

   typedef struct {
      string       tag;
      bit          dut;
      logic [15:0] total;
      logic [3:0]  item;
      logic [2:0]  rcoin;
      logic        busy;
      int          wt;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] avail_of(input logic [15:0] t);
      return {t >= 16'd2000, t >= 16'd1000, t >= 16'd500, t >= 16'd400};
   endfunction

   // Drive one cycle of stimulus and queue what the DUT must show after the next edge.
   task automatic step(input string tag, input bit d, input bit rst,
                       input logic [2:0] c, input logic [3:0] s, input logic r,
                       input logic [15:0] t, input logic [3:0] it, input logic [2:0] rc,
                       input logic b, input int w);
      exp_t x;
      reset_n = !rst;
      coin_a = d ? 3'b0 : c;  sel_a = d ? 4'b0 : s;  ret_a = d ? 1'b0 : r;
      coin_b = d ? c : 3'b0;  sel_b = d ? s : 4'b0;  ret_b = d ? r : 1'b0;
      x.tag = tag; x.dut = d; x.total = t; x.item = it; x.rcoin = rc; x.busy = b; x.wt = w;
      sb.push_back(x);
      @(posedge clk);
      #2;
      coin_a = '0; sel_a = '0; ret_a = 1'b0;
      coin_b = '0; sel_b = '0; ret_b = 1'b0;
   endtask

   always @(posedge clk) begin
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         if (!e.dut) begin
            check({e.tag, ".total"}, 32'(total_a), 32'(e.total));
            check({e.tag, ".avail"}, 32'(avail_a), 32'(avail_of(e.total)));
            check({e.tag, ".item"},  32'(item_a),  32'(e.item));
            check({e.tag, ".rcoin"}, 32'(rcoin_a), 32'(e.rcoin));
            check({e.tag, ".busy"},  32'(busy_a),  32'(e.busy));
            if (e.wt >= 0) check({e.tag, ".wait"}, 32'(wait_a), 32'(e.wt));
         end else begin
            check({e.tag, ".total"}, 32'(total_b), 32'(e.total));
            check({e.tag, ".avail"}, 32'(avail_b), 32'(avail_of(e.total)));
            check({e.tag, ".item"},  32'(item_b),  32'(e.item));
            check({e.tag, ".rcoin"}, 32'(rcoin_b), 32'(e.rcoin));
            check({e.tag, ".busy"},  32'(busy_b),  32'(e.busy));
            if (e.wt >= 0) check({e.tag, ".wait"}, 32'(wait_b), 32'(e.wt));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst.total", 32'(total_a), 32'd0);
      check("rst.avail", 32'(avail_a), 32'd0);
      check("rst.item",  32'(item_a),  32'd0);
      check("rst.rcoin", 32'(rcoin_a), 32'd0);
      check("rst.wait",  32'(wait_a),  32'd0);
      check("rst.busy",  32'(busy_a),  32'd0);
      #1;

      //    tag           d  rst coin    sel      ret   total    item     rcoin   busy wait
      step("buy_coin",   0, 0, 3'b010, 4'b0000, 0, 16'd500,  4'b0000, 3'b000, 0, 100);
      step("buy_sel",    0, 0, 3'b000, 4'b0010, 0, 16'd0,    4'b0010, 3'b000, 0, 100);
      step("buy_after",  0, 0, 3'b000, 4'b0000, 0, 16'd0,    4'b0000, 3'b000, 0, 99);
      step("zero_ret",   0, 0, 3'b000, 4'b0000, 1, 16'd0,    4'b0000, 3'b000, 1, -1);
      step("zero_idle",  0, 0, 3'b000, 4'b0000, 0, 16'd0,    4'b0000, 3'b000, 0, -1);

      step("mc_coin",    0, 0, 3'b101, 4'b0000, 0, 16'd1100, 4'b0000, 3'b000, 0, 100);
      step("mc_ret",     0, 0, 3'b000, 4'b0000, 1, 16'd1100, 4'b0000, 3'b000, 1, -1);
      step("mc_c2",      0, 0, 3'b001, 4'b0001, 0, 16'd100,  4'b0000, 3'b100, 1, -1);
      step("mc_c0",      0, 0, 3'b000, 4'b0000, 0, 16'd0,    4'b0000, 3'b001, 1, -1);
      step("mc_idle",    0, 0, 3'b000, 4'b0000, 0, 16'd0,    4'b0000, 3'b000, 0, -1);
      step("idle_ign",   0, 0, 3'b000, 4'b0001, 1, 16'd0,    4'b0000, 3'b000, 0, -1);

      step("ins_coin",   0, 0, 3'b001, 4'b0000, 0, 16'd100,  4'b0000, 3'b000, 0, 100);
      step("ins_sel",    0, 0, 3'b000, 4'b0001, 0, 16'd100,  4'b0000, 3'b000, 0, 99);
      step("ins_sel2",   0, 0, 3'b000, 4'b0001, 0, 16'd100,  4'b0000, 3'b000, 0, 98);
      step("ins_ret",    0, 0, 3'b000, 4'b0000, 1, 16'd100,  4'b0000, 3'b000, 1, -1);
      step("ins_c0",     0, 0, 3'b000, 4'b0000, 0, 16'd0,    4'b0000, 3'b001, 1, -1);
      step("ins_idle",   0, 0, 3'b000, 4'b0000, 0, 16'd0,    4'b0000, 3'b000, 0, -1);

      step("to_coin",    0, 0, 3'b001, 4'b0000, 0, 16'd100,  4'b0000, 3'b000, 0, 100);
      for (int k = 1; k <= 100; k++)
         step("to_wait", 0, 0, 3'b000, 4'b0000, 0, 16'd100,  4'b0000, 3'b000, 0, 100 - k);
      step("to_enter",   0, 0, 3'b000, 4'b0000, 0, 16'd100,  4'b0000, 3'b000, 1, -1);
      step("to_c0",      0, 0, 3'b000, 4'b0000, 0, 16'd0,    4'b0000, 3'b001, 1, -1);
      step("to_idle",    0, 0, 3'b000, 4'b0000, 0, 16'd0,    4'b0000, 3'b000, 0, -1);

      step("pr_coin",    0, 0, 3'b010, 4'b0000, 0, 16'd500,  4'b0000, 3'b000, 0, 100);
      step("pr_both",    0, 0, 3'b001, 4'b0001, 0, 16'd600,  4'b0000, 3'b000, 0, 100);
      step("pr_low",     0, 0, 3'b000, 4'b0011, 0, 16'd200,  4'b0001, 3'b000, 0, 100);
      step("pr_poor",    0, 0, 3'b000, 4'b1000, 0, 16'd200,  4'b0000, 3'b000, 0, 99);
      step("pr_ret",     0, 0, 3'b000, 4'b0000, 1, 16'd200,  4'b0000, 3'b000, 1, -1);
      step("pr_c0a",     0, 0, 3'b000, 4'b0000, 0, 16'd100,  4'b0000, 3'b001, 1, -1);
      step("pr_c0b",     0, 0, 3'b000, 4'b0000, 0, 16'd0,    4'b0000, 3'b001, 1, -1);
      step("pr_idle",    0, 0, 3'b000, 4'b0000, 0, 16'd0,    4'b0000, 3'b000, 0, -1);

      step("ov_idle_bnc",1, 0, 3'b110, 4'b0000, 0, 16'd0,    4'b0000, 3'b110, 0, 0);
      step("ov_fill",    1, 0, 3'b100, 4'b0000, 0, 16'd1000, 4'b0000, 3'b000, 0, 100);
      step("ov_bnc",     1, 0, 3'b001, 4'b0000, 0, 16'd1000, 4'b0000, 3'b001, 0, 100);
      step("ov_after",   1, 0, 3'b000, 4'b0000, 0, 16'd1000, 4'b0000, 3'b000, 0, 99);

      step("rs_c2a",     0, 0, 3'b100, 4'b0000, 0, 16'd1000, 4'b0000, 3'b000, 0, 100);
      step("rs_c2b",     0, 0, 3'b100, 4'b0000, 0, 16'd2000, 4'b0000, 3'b000, 0, 100);
      step("rs_ret",     0, 0, 3'b000, 4'b0000, 1, 16'd2000, 4'b0000, 3'b000, 1, -1);
      step("rs_c2",      0, 0, 3'b000, 4'b0000, 0, 16'd1000, 4'b0000, 3'b100, 1, -1);
      step("rs_rst",     0, 1, 3'b000, 4'b0000, 0, 16'd0,    4'b0000, 3'b000, 0, 0);
      step("rs_idle",    0, 0, 3'b000, 4'b0000, 0, 16'd0,    4'b0000, 3'b000, 0, 0);

      @(posedge clk);
      #2;
      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
